// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the default bit period
// used by both the transmitter and the receiver.
package uart_pkg;

  // 50 MHz system clock at 115200 baud.
  parameter int unsigned ClksPerBitDefault = 434;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StStartBit  = 3'd1,
    StDataBits  = 3'd2,
    StStopBit   = 3'd3,
    StCleanup   = 3'd4,
    StBreakWait = 3'd5
  } rx_state_e;

  // Offset from the detected falling edge to the middle of the start bit.
  function automatic int unsigned half_bit(input int unsigned clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receive-side UART bundle: serial line in, recovered byte and status out.
// The slave modport is the receiver; the master modport is the line driver / consumer.
interface uart_receiver_if;

  logic       rx_serial;
  logic [7:0] rx_byte;
  logic       rx_data_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  modport master (
    output rx_serial,
    input  rx_byte,
    input  rx_data_valid,
    input  rx_frame_err,
    input  rx_busy
  );

  modport slave (
    input  rx_serial,
    output rx_byte,
    output rx_data_valid,
    output rx_frame_err,
    output rx_busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; resets to 1 so an
// idle-high line does not look like an edge when reset is released.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid / framing-error pulses,
// and no re-arm while the line is held low after a bad stop bit (break).
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned ClksPerBit = ClksPerBitDefault
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  uart_receiver_if.slave  rx_if
);

  localparam int unsigned HalfBit = half_bit(ClksPerBit);
  localparam int unsigned CntW    = $clog2(ClksPerBit);

  localparam logic [CntW-1:0] HalfCnt = CntW'(HalfBit);
  localparam logic [CntW-1:0] LastCnt = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  if (ClksPerBit < 4) begin : g_bad_param
    $error("uart_receiver: ClksPerBit must be at least 4");
  end

  rx_state_e       state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [2:0]      index_q, index_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q,  byte_d;
  logic            valid_q, valid_d;
  logic            ferr_q,  ferr_d;
  logic            rx_s;

  sync_2ff u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rx_if.rx_serial),
    .q_o    (rx_s)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      count_q <= '0;
      index_q <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    index_d = index_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      StIdle: begin
        count_d = '0;
        index_d = '0;
        if (!rx_s) begin
          state_d = StStartBit;
        end
      end

      StStartBit: begin
        if (count_q == HalfCnt) begin
          count_d = '0;
          // A line that is high again at mid-start was a glitch, not a frame.
          state_d = rx_s ? StIdle : StDataBits;
        end else begin
          count_d = count_q + CntOne;
        end
      end

      StDataBits: begin
        if (count_q == LastCnt) begin
          count_d = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (index_q == 3'd7) begin
            state_d = StStopBit;
          end else begin
            index_d = index_q + 3'd1;
          end
        end else begin
          count_d = count_q + CntOne;
        end
      end

      StStopBit: begin
        if (count_q == LastCnt) begin
          count_d = '0;
          if (rx_s) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            state_d = StCleanup;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreakWait;
          end
        end else begin
          count_d = count_q + CntOne;
        end
      end

      StCleanup: begin
        count_d = '0;
        index_d = '0;
        state_d = StIdle;
      end

      StBreakWait: begin
        // Only a return to idle-high re-arms start detection.
        count_d = '0;
        index_d = '0;
        if (rx_s) begin
          state_d = StIdle;
        end
      end

      default: begin
        count_d = '0;
        index_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  assign rx_if.rx_byte       = byte_q;
  assign rx_if.rx_data_valid = valid_q;
  assign rx_if.rx_frame_err  = ferr_q;
  assign rx_if.rx_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frame table at 16 clocks/bit, hand-written
// glitch, break and mid-frame reset sequences, and a default-rate instance.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int unsigned Cpb     = 16;
  localparam int unsigned CpbDef  = ClksPerBitDefault;
  localparam int unsigned CpbFast = 421;  // about 3% fast against 434
  // Pin drop at posedge+1, two synchroniser edges, then t0+4124 for the pulse.
  localparam int ExpLatEdges = 4 + int'((CpbDef - 1) / 2) + 9 * int'(CpbDef);
  localparam int NVec = 6;

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    int unsigned gap;
    int          exp_v;
    int          exp_f;
    logic [7:0]  exp_byte;
  } vec_t;

  logic clk;
  logic rst_n;
  logic line16;
  logic line434;

  int  checks;
  int  failures;
  int  vcnt16, fcnt16, vcnt434, fcnt434, both_cnt;
  time tv434;

  uart_receiver_if if16 ();
  uart_receiver_if if434 ();

  assign if16.rx_serial  = line16;
  assign if434.rx_serial = line434;

  uart_receiver #(.ClksPerBit(Cpb)) u_dut16 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .rx_if  (if16)
  );

  uart_receiver #(.ClksPerBit(CpbDef)) u_dut434 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .rx_if  (if434)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (if16.rx_data_valid)  vcnt16++;
    if (if16.rx_frame_err)   fcnt16++;
    if (if434.rx_data_valid) begin
      vcnt434++;
      tv434 = $time;
    end
    if (if434.rx_frame_err) fcnt434++;
    if ((if16.rx_data_valid && if16.rx_frame_err) ||
        (if434.rx_data_valid && if434.rx_frame_err)) both_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Holds the line for one bit period; always returns at posedge+1.
  task automatic drive_bit(input bit sel, input logic val, input int unsigned period);
    if (sel) line434 = val;
    else     line16  = val;
    repeat (period) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] data, input logic stop,
                            input int unsigned period);
    drive_bit(sel, 1'b0, period);
    for (int b = 0; b < 8; b++) drive_bit(sel, data[b], period);
    drive_bit(sel, stop, period);
  endtask

  vec_t vecs[NVec];

  initial begin
    int v0, f0;
    time t_drop;
    logic [7:0] d5a;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, gap: 2, exp_v: 1, exp_f: 0, exp_byte: 8'hA5};
    vecs[1] = '{data: 8'h00, stop: 1'b1, gap: 0, exp_v: 1, exp_f: 0, exp_byte: 8'h00};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, gap: 2, exp_v: 1, exp_f: 0, exp_byte: 8'hFF};
    vecs[3] = '{data: 8'h6B, stop: 1'b1, gap: 1, exp_v: 1, exp_f: 0, exp_byte: 8'h6B};
    vecs[4] = '{data: 8'hC3, stop: 1'b0, gap: 2, exp_v: 0, exp_f: 1, exp_byte: 8'h6B};
    vecs[5] = '{data: 8'h12, stop: 1'b1, gap: 2, exp_v: 1, exp_f: 0, exp_byte: 8'h12};

    checks = 0; failures = 0;
    vcnt16 = 0; fcnt16 = 0; vcnt434 = 0; fcnt434 = 0; both_cnt = 0; tv434 = 0;
    rst_n = 1'b0; line16 = 1'b1; line434 = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_byte",  32'(if16.rx_byte), 32'h00);
    check("reset_valid", 32'(if16.rx_data_valid), 0);
    check("reset_ferr",  32'(if16.rx_frame_err), 0);
    check("reset_busy",  32'(if16.rx_busy), 0);
    check("reset_busy434", 32'(if434.rx_busy), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NVec; i++) begin
      v0 = vcnt16; f0 = fcnt16;
      send_frame(1'b0, vecs[i].data, vecs[i].stop, Cpb);
      repeat (vecs[i].gap) drive_bit(1'b0, 1'b1, Cpb);
      check($sformatf("vec%0d_valid_cnt", i), 32'(vcnt16 - v0), 32'(vecs[i].exp_v));
      check($sformatf("vec%0d_ferr_cnt", i), 32'(fcnt16 - f0), 32'(vecs[i].exp_f));
      check($sformatf("vec%0d_byte", i), 32'(if16.rx_byte), 32'(vecs[i].exp_byte));
      if (vecs[i].gap > 0) check($sformatf("vec%0d_busy", i), 32'(if16.rx_busy), 0);
    end

    // Glitch shorter than half a bit.
    v0 = vcnt16; f0 = fcnt16;
    line16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    line16 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("glitch_busy_high", 32'(if16.rx_busy), 1);
    drive_bit(1'b0, 1'b1, Cpb);
    drive_bit(1'b0, 1'b1, Cpb);
    check("glitch_busy_low", 32'(if16.rx_busy), 0);
    check("glitch_valid_cnt", 32'(vcnt16 - v0), 0);
    check("glitch_ferr_cnt", 32'(fcnt16 - f0), 0);

    // Bad stop bit followed by a long break.
    v0 = vcnt16; f0 = fcnt16;
    send_frame(1'b0, 8'h3C, 1'b0, Cpb);
    repeat (100) drive_bit(1'b0, 1'b0, Cpb);
    check("break_ferr_cnt", 32'(fcnt16 - f0), 1);
    check("break_valid_cnt", 32'(vcnt16 - v0), 0);
    check("break_byte_kept", 32'(if16.rx_byte), 32'h12);
    check("break_busy_held", 32'(if16.rx_busy), 1);
    drive_bit(1'b0, 1'b1, Cpb);
    drive_bit(1'b0, 1'b1, Cpb);
    check("break_busy_release", 32'(if16.rx_busy), 0);
    check("break_ferr_once", 32'(fcnt16 - f0), 1);

    // Reset asserted in the middle of data bit 4 of 8'h5A.
    d5a = 8'h5A;
    v0 = vcnt16; f0 = fcnt16;
    drive_bit(1'b0, 1'b0, Cpb);
    for (int b = 0; b < 4; b++) drive_bit(1'b0, d5a[b], Cpb);
    line16 = d5a[4];
    repeat (8) @(posedge clk);
    #1;
    check("rst_mid_busy_before", 32'(if16.rx_busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_byte", 32'(if16.rx_byte), 32'h00);
    check("rst_mid_valid", 32'(if16.rx_data_valid), 0);
    check("rst_mid_ferr", 32'(if16.rx_frame_err), 0);
    check("rst_mid_busy", 32'(if16.rx_busy), 0);
    line16 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_bit(1'b0, 1'b1, Cpb);
    drive_bit(1'b0, 1'b1, Cpb);
    check("rst_no_pulse", 32'((vcnt16 - v0) + (fcnt16 - f0)), 0);
    send_frame(1'b0, 8'h81, 1'b1, Cpb);
    drive_bit(1'b0, 1'b1, Cpb);
    drive_bit(1'b0, 1'b1, Cpb);
    check("post_rst_valid_cnt", 32'(vcnt16 - v0), 1);
    check("post_rst_byte", 32'(if16.rx_byte), 32'h81);
    check("post_rst_ferr_cnt", 32'(fcnt16 - f0), 0);

    // Default bit period: nominal rate with latency, then a 3% fast transmitter.
    v0 = vcnt434; f0 = fcnt434;
    t_drop = $time;
    send_frame(1'b1, 8'h55, 1'b1, CpbDef);
    drive_bit(1'b1, 1'b1, CpbDef);
    check("def_valid_cnt", 32'(vcnt434 - v0), 1);
    check("def_byte", 32'(if434.rx_byte), 32'h55);
    check("def_ferr_cnt", 32'(fcnt434 - f0), 0);
    check("def_latency_edges", 32'((tv434 - t_drop) / 10), 32'(ExpLatEdges));
    v0 = vcnt434;
    send_frame(1'b1, 8'h55, 1'b1, CpbFast);
    drive_bit(1'b1, 1'b1, CpbDef);
    check("fast_valid_cnt", 32'(vcnt434 - v0), 1);
    check("fast_byte", 32'(if434.rx_byte), 32'h55);
    check("fast_ferr_cnt", 32'(fcnt434 - f0), 0);
    check("fast_busy", 32'(if434.rx_busy), 0);

    check("never_valid_and_ferr", 32'(both_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
